double_adder_arbiter: RTL and testbench

Round-robin controller that shares one multi-cycle `double_adder` among `NUM_REQ` requesters, such as neuron accumulation lanes. It accepts an IEEE-754 double operand pair from one requester at a time and sequences the adder's compute/complete handshake. It then routes the sum back to the granted requester. A watchdog bounds each operation, so a hung adder cannot stall the network.

---
 rtl/double_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/double_adder_arbiter.sv | 139 +++++++++++++
 tb/tb_double_adder_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/double_pkg.sv
// ---------------------------------------------------------------------------
// double_pkg: shared types and constants for the double-precision blocks. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package double_pkg;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef logic [63:0] operand_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, scanning upward from last_grant+1. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  localparam logic [IDX_W:0] C_NUM = (IDX_W+1)'(NUM_REQ);

  // One spare bit so last_grant + offset never overflows before the wrap.
  logic [IDX_W:0] w_idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, last_grant_i} + (IDX_W+1)'(k);
      if (w_idx >= C_NUM) begin
        w_idx = w_idx - C_NUM;
      end
      if (!any_o && req_i[w_idx[IDX_W-1:0]]) begin
        any_o                         = 1'b1;
        grant_o[w_idx[IDX_W-1:0]]     = 1'b1;
        grant_idx_o                   = w_idx[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/double_adder_arbiter.sv
// ---------------------------------------------------------------------------
// double_adder_arbiter: shares one four-phase double adder among NUM_REQ requesters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module double_adder_arbiter
  import double_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*64-1:0] req_a_i,
  input  logic [NUM_REQ*64-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  input  logic [NUM_REQ-1:0]    resp_ready_i,
  output logic [63:0]           resp_z_o,
  output logic                  resp_err_o,
  output logic                  add_compute_o,
  output logic [63:0]           add_a_o,
  output logic [63:0]           add_b_o,
  input  logic [63:0]           add_z_i,
  input  logic                  add_complete_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] C_LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_e           state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   owner_oh_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [CNT_W-1:0]     wdog_q;
  operand_t             add_a_q;
  operand_t             add_b_q;
  operand_t             resp_z_q;
  logic                 resp_err_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  operand_t             sel_a;
  operand_t             sel_b;
  logic                 owner_ack;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_o        (grant_any)
  );

  // The grant is one-hot, so an AND-OR mux picks the winner's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a_i[i*64 +: 64];
        sel_b = sel_b | req_b_i[i*64 +: 64];
      end
    end
  end

  assign owner_ack     = |(resp_ready_i & owner_oh_q);
  assign req_ready_o   = (clk_en_i && state_q == ST_IDLE) ? grant : '0;
  assign resp_valid_o  = (clk_en_i && state_q == ST_RESPOND) ? owner_oh_q : '0;
  assign add_compute_o = (state_q == ST_BUSY);
  assign add_a_o       = add_a_q;
  assign add_b_o       = add_b_q;
  assign resp_z_o      = resp_z_q;
  assign resp_err_o    = resp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      owner_oh_q   <= '0;
      last_grant_q <= C_LAST_INIT;
      wdog_q       <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_z_q     <= '0;
      resp_err_q   <= 1'b0;
    end else if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            add_a_q    <= sel_a;
            add_b_q    <= sel_b;
            owner_q    <= grant_idx;
            owner_oh_q <= grant;
            wdog_q     <= '0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Completion is checked first so it wins a tie with the watchdog.
          if (add_complete_i) begin
            resp_z_q   <= add_z_i;
            resp_err_q <= 1'b0;
            state_q    <= ST_RELEASE;
          end else if (wdog_q == C_CNT_LAST) begin
            resp_z_q   <= QNAN;
            resp_err_q <= 1'b1;
            state_q    <= ST_RELEASE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!add_complete_i) begin
            state_q <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (owner_ack) begin
            last_grant_q <= owner_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_double_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_double_adder_arbiter: directed stimulus against a transaction-level model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_double_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [63:0]           resp_z;
  logic                  resp_err;
  logic                  add_compute;
  logic [63:0]           add_a;
  logic [63:0]           add_b;
  logic [63:0]           add_z;
  logic                  add_complete;

  int n_vec = 0;
  int n_err = 0;

  double_adder_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en_i       (clk_en),
    .req_valid_i    (req_valid),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_ready_o    (req_ready),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_z_o       (resp_z),
    .resp_err_o     (resp_err),
    .add_compute_o  (add_compute),
    .add_a_o        (add_a),
    .add_b_o        (add_b),
    .add_z_i        (add_z),
    .add_complete_i (add_complete)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Adder stub: complete rises stub_lat enabled cycles after compute, falls once compute drops.
  int stub_lat  = 3;
  bit stub_hang = 1'b0;
  int stub_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_complete <= 1'b0;
      stub_cnt     <= 0;
    end else if (clk_en) begin
      if (add_compute) begin
        if (!stub_hang && stub_cnt >= stub_lat - 1) add_complete <= 1'b1;
        stub_cnt <= stub_cnt + 1;
      end else begin
        add_complete <= 1'b0;
        stub_cnt     <= 0;
      end
    end
  end
  assign add_z = $realtobits($bitstoreal(add_a) + $bitstoreal(add_b));

  int cyc = 0;
  int en_edges = 0;
  always @(posedge clk) begin
    cyc++;
    if (clk_en && rst_n) en_edges++;
  end

  function automatic int rr_pick(logic [NUM_REQ-1:0] v, int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i = (last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Model: one outstanding operation, timed in enabled cycles from the grant edge.
  bit          m_busy = 1'b0;
  int          m_last = NUM_REQ - 1;
  int          m_owner;
  logic [63:0] m_a, m_b, m_z;
  logic        m_err;
  int          m_grant_en, m_grant_cyc, m_done_off, m_resp_off;
  bit          m_seen_valid, m_seen_err;
  int          m_lat_cyc, m_err_cyc;
  int          resp_count = 0;
  int          grant_log[$];
  logic [63:0] dut_z_log[$];
  logic [63:0] last_dut_z;
  logic        last_dut_err;
  int          last_dut_owner;

  always @(negedge clk) begin : compare
    int g;
    int d;
    bit normal;
    logic [NUM_REQ-1:0] ev;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = NUM_REQ - 1;
    end else if (!clk_en) begin
      chk("ready_gated", req_ready, 0);
      chk("valid_gated", resp_valid, 0);
    end else if (!m_busy) begin
      g  = rr_pick(req_valid, m_last);
      ev = (g >= 0) ? NUM_REQ'(1 << g) : '0;
      chk("grant", req_ready, ev);
      chk("idle_compute", add_compute, 0);
      chk("idle_resp_valid", resp_valid, 0);
      if (g >= 0) begin
        m_busy      = 1'b1;
        m_owner     = g;
        m_a         = req_a[g*64 +: 64];
        m_b         = req_b[g*64 +: 64];
        normal      = !stub_hang && (stub_lat + 1 <= TIMEOUT);
        m_z         = normal ? $realtobits($bitstoreal(m_a) + $bitstoreal(m_b)) : QNAN;
        m_err       = !normal;
        m_done_off  = normal ? stub_lat + 1 : TIMEOUT;
        m_resp_off  = normal ? stub_lat + 3 : TIMEOUT + 1;
        m_grant_en  = en_edges + 1;
        m_grant_cyc = cyc + 1;
        m_seen_valid = 1'b0;
        m_seen_err   = 1'b0;
        m_lat_cyc    = -1;
        m_err_cyc    = -1;
        grant_log.push_back(g);
      end
    end else begin
      d = en_edges - m_grant_en;
      chk("busy_ready", req_ready, 0);
      chk("compute", add_compute, (d < m_done_off));
      if (d < m_done_off) begin
        chk("add_a", add_a, m_a);
        chk("add_b", add_b, m_b);
      end else begin
        chk("resp_z", resp_z, m_z);
        chk("resp_err", resp_err, m_err);
      end
      ev = (d >= m_resp_off) ? NUM_REQ'(1 << m_owner) : '0;
      chk("resp_valid", resp_valid, ev);
      if (resp_err && !m_seen_err) begin
        m_seen_err = 1'b1;
        m_err_cyc  = cyc - m_grant_cyc;
      end
      if (resp_valid != 0 && !m_seen_valid) begin
        m_seen_valid = 1'b1;
        m_lat_cyc    = cyc - m_grant_cyc;
      end
      if (d >= m_resp_off && resp_ready[m_owner]) begin
        m_busy         = 1'b0;
        m_last         = m_owner;
        last_dut_z     = resp_z;
        last_dut_err   = resp_err;
        last_dut_owner = -1;
        for (int i = 0; i < NUM_REQ; i++) if (resp_valid[i]) last_dut_owner = i;
        dut_z_log.push_back(resp_z);
        resp_count++;
      end
    end
  end

  task automatic set_req(input int i, input real a, input real b);
    req_a[i*64 +: 64] = $realtobits(a);
    req_b[i*64 +: 64] = $realtobits(b);
  endtask

  task automatic one_req(input int i);
    @(posedge clk); #1 req_valid = NUM_REQ'(1 << i);
    @(posedge clk); #1 req_valid = '0;
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n = 0;
    while (resp_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("wait_budget", resp_count, target);
  endtask

  initial begin : watchdog_guard
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int s;
    int n;
    rst_n      = 1'b0;
    clk_en     = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_compute", add_compute, 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    rst_n = 1'b1;

    // Fairness: all valid, distinct operands.
    stub_lat = 2;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, real'(i + 1), 0.25 * real'(i + 1));
    s = grant_log.size();
    @(posedge clk); #1 req_valid = '1;
    wait_resp(5, 200);
    req_valid = '0;
    chk("fair_g0", grant_log[s],   0);
    chk("fair_g1", grant_log[s+1], 1);
    chk("fair_g2", grant_log[s+2], 2);
    chk("fair_g3", grant_log[s+3], 3);
    chk("fair_g4", grant_log[s+4], 0);
    chk("fair_z2", dut_z_log[s+2], 64'h400E_0000_0000_0000);

    // Single request: 1.0 + 2.0.
    stub_lat = 3;
    set_req(0, 1.0, 2.0);
    one_req(0);
    wait_resp(6, 50);
    chk("single_z", last_dut_z, 64'h4008_0000_0000_0000);
    chk("single_err", last_dut_err, 0);
    chk("single_owner", last_dut_owner, 0);
    chk("single_lat", m_lat_cyc, 6);

    // Backpressure: owner withholds resp_ready; others keep requesting.
    stub_lat   = 2;
    resp_ready = '0;
    set_req(1, 5.0, 6.0);
    set_req(3, 0.5, 0.25);
    @(posedge clk); #1 req_valid = 4'b1010;
    n = 0;
    while (resp_valid == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1 resp_ready = 4'b1101;
    @(posedge clk); #1;
    chk("bp_hold_valid", resp_valid, 4'b0010);
    chk("bp_hold_z", resp_z, 64'h4026_0000_0000_0000);
    resp_ready = '1;
    wait_resp(8, 100);
    req_valid = '0;
    chk("bp_g_first", grant_log[grant_log.size()-2], 1);
    chk("bp_g_second", grant_log[grant_log.size()-1], 3);

    // Watchdog: adder never completes.
    stub_hang = 1'b1;
    set_req(2, 7.0, 8.0);
    one_req(2);
    wait_resp(9, 50);
    chk("wd_z", last_dut_z, QNAN);
    chk("wd_err", last_dut_err, 1);
    chk("wd_err_cyc", m_err_cyc, TIMEOUT);
    chk("wd_lat", m_lat_cyc, TIMEOUT + 1);
    stub_hang = 1'b0;
    set_req(2, 0.5, 0.5);
    one_req(2);
    wait_resp(10, 50);
    chk("recover_z", last_dut_z, 64'h3FF0_0000_0000_0000);
    chk("recover_err", last_dut_err, 0);

    // Completion and watchdog in the same cycle: completion wins.
    stub_lat = TIMEOUT - 1;
    set_req(1, 1.0, 1.0);
    one_req(1);
    wait_resp(11, 50);
    chk("tie_z", last_dut_z, 64'h4000_0000_0000_0000);
    chk("tie_err", last_dut_err, 0);
    chk("tie_lat", m_lat_cyc, 10);

    // Clock enable low for 3 cycles mid-BUSY.
    stub_lat = 2;
    set_req(1, 2.0, 2.0);
    one_req(1);
    @(posedge clk); #1 clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 clk_en = 1'b1;
    wait_resp(12, 50);
    chk("en_z", last_dut_z, 64'h4010_0000_0000_0000);
    chk("en_lat", m_lat_cyc, 8);

    // Asynchronous reset mid-BUSY, then requester 0 must win.
    set_req(0, 3.0, 3.0);
    set_req(2, 9.0, 9.0);
    @(posedge clk); #1 req_valid = 4'b0101;
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);
    chk("pre_rst_owner", grant_log[grant_log.size()-1], 2);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_compute", add_compute, 0);
    chk("arst_resp_z", resp_z, 0);
    chk("arst_resp_err", resp_err, 0);
    chk("arst_add_a", add_a, 0);
    chk("arst_add_b", add_b, 0);
    chk("arst_req_ready", req_ready, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1 req_valid = 4'b0101;
    @(posedge clk); #1 req_valid = '0;
    wait_resp(13, 50);
    chk("post_rst_grant", grant_log[grant_log.size()-1], 0);
    chk("post_rst_z", last_dut_z, 64'h4018_0000_0000_0000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
